// File: rtl/row_readout.sv
// Row-sequenced pixel readout: selects one sensor row at a time, captures it
// into a local buffer and streams the pixels out over a valid/ready handshake.
module row_readout #(
    parameter int PIXEL_ARRAY_WIDTH  = 2,
    parameter int PIXEL_ARRAY_HEIGHT = 2,
    localparam int ROW_W = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1,
    localparam int COL_W = (PIXEL_ARRAY_WIDTH > 1) ? $clog2(PIXEL_ARRAY_WIDTH) : 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                START,
    input  logic [PIXEL_ARRAY_WIDTH-1:0][7:0]   ROW_DATA,
    output logic [PIXEL_ARRAY_HEIGHT-1:0]       READ_ROW,
    output logic [7:0]                          PIXEL_DATA,
    output logic                                PIXEL_VALID,
    input  logic                                PIXEL_READY,
    output logic [ROW_W-1:0]                    PIXEL_ROW,
    output logic [COL_W-1:0]                    PIXEL_COL,
    output logic                                FRAME_LAST,
    output logic                                BUSY
);

    // state   | meaning
    // IDLE    | waiting for START, no row selected
    // SETTLE  | row selected, analog path settling
    // CAPTURE | row selected, ROW_DATA registered into the buffer at cycle end
    // STREAM  | buffered pixels offered one per transfer, row deselected
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_STREAM  = 2'd3
    } state_t;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(PIXEL_ARRAY_HEIGHT - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(PIXEL_ARRAY_WIDTH - 1);

    state_t                              state_q, state_d;
    logic [ROW_W-1:0]                    row_q, row_d;
    logic [COL_W-1:0]                    col_q, col_d;
    logic [PIXEL_ARRAY_WIDTH-1:0][7:0]   buf_q, buf_d;

    logic [PIXEL_ARRAY_HEIGHT-1:0]       read_row;
    logic                                valid;
    logic                                last_row;
    logic                                last_col;

    assign last_row = (row_q == LAST_ROW);
    assign last_col = (col_q == LAST_COL);

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        buf_d    = buf_q;
        read_row = '0;
        valid    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d = ST_SETTLE;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            ST_SETTLE: begin
                read_row[row_q] = 1'b1;
                state_d         = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                read_row[row_q] = 1'b1;
                buf_d           = ROW_DATA;
                state_d         = ST_STREAM;
            end
            ST_STREAM: begin
                valid = 1'b1;
                // Indices only move on an accepted transfer, so a stalled
                // pixel keeps data, coordinates and FRAME_LAST steady.
                if (PIXEL_READY) begin
                    if (last_col) begin
                        col_d = '0;
                        if (last_row) begin
                            row_d   = '0;
                            state_d = ST_IDLE;
                        end else begin
                            row_d   = row_q + ROW_W'(1);
                            state_d = ST_SETTLE;
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            buf_q   <= buf_d;
        end
    end

    assign READ_ROW    = read_row;
    assign PIXEL_VALID = valid;
    assign PIXEL_DATA  = valid ? buf_q[col_q] : 8'h00;
    assign PIXEL_ROW   = row_q;
    assign PIXEL_COL   = col_q;
    assign FRAME_LAST  = valid & last_row & last_col;
    assign BUSY        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_row_readout.sv
// Bench for row_readout: a pixel-array model feeds ROW_DATA, a scoreboard of
// expected pixels is filled per accepted frame and drained by a monitor.
module tb_row_readout;

    localparam int W  = 2;
    localparam int H  = 2;
    localparam int RW = 1;
    localparam int CW = 1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic [W-1:0][7:0]    row_data;
    logic [H-1:0]         read_row;
    logic [7:0]           pixel_data;
    logic                 pixel_valid;
    logic                 pixel_ready;
    logic [RW-1:0]        pixel_row;
    logic [CW-1:0]        pixel_col;
    logic                 frame_last;
    logic                 busy;

    always #5 clk = ~clk;

    row_readout #(.PIXEL_ARRAY_WIDTH(W), .PIXEL_ARRAY_HEIGHT(H)) dut (
        .clk         (clk),
        .reset       (reset),
        .START       (start),
        .ROW_DATA    (row_data),
        .READ_ROW    (read_row),
        .PIXEL_DATA  (pixel_data),
        .PIXEL_VALID (pixel_valid),
        .PIXEL_READY (pixel_ready),
        .PIXEL_ROW   (pixel_row),
        .PIXEL_COL   (pixel_col),
        .FRAME_LAST  (frame_last),
        .BUSY        (busy)
    );

    typedef struct {
        logic [7:0] d;
        int         r;
        int         c;
        bit         last;
    } pix_t;

    pix_t       sb[$];
    pix_t       mon_e;
    logic [7:0] mem [H][W];
    logic [H-1:0] prev_rr;
    logic [7:0] junk;
    int vectors = 0;
    int miscompares = 0;

    // Sensor model: a row's values only appear once it has been selected for
    // a full cycle; otherwise the column lines carry random junk.
    always @(posedge clk) begin
        prev_rr <= read_row;
        junk    <= 8'($urandom);
    end

    always_comb begin
        row_data = {W{junk}};
        if (read_row != '0 && read_row == prev_rr) begin
            for (int r = 0; r < H; r++)
                if (read_row[r])
                    for (int c = 0; c < W; c++)
                        row_data[c] = mem[r][c];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame();
        pix_t p;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                p.d    = mem[r][c];
                p.r    = r;
                p.c    = c;
                p.last = (r == H - 1) && (c == W - 1);
                sb.push_back(p);
            end
    endtask

    task automatic rand_mem();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                mem[r][c] = 8'($urandom);
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_read_row"}, 32'(read_row), 0);
        chk({name, "_data"}, 32'(pixel_data), 0);
        chk({name, "_valid"}, 32'(pixel_valid), 0);
        chk({name, "_row"}, 32'(pixel_row), 0);
        chk({name, "_col"}, 32'(pixel_col), 0);
        chk({name, "_last"}, 32'(frame_last), 0);
        chk({name, "_busy"}, 32'(busy), 0);
    endtask

    // Bounded drain: returns on the first cycle the scoreboard is empty.
    task automatic wait_empty(input string name, input bit rand_io);
        int n;
        n = 0;
        while (sb.size() != 0) begin
            step();
            n++;
            if (sb.size() == 0) break;
            if (n > 300) begin
                miscompares++;
                vectors++;
                $display("FAIL %s_timeout: %0d pixels still pending, expected 0", name, sb.size());
                sb.delete();
                break;
            end
            if (rand_io) begin
                pixel_ready = ($urandom % 4) != 0;
                start       = ($urandom % 6) == 0;
            end
        end
    endtask

    // Monitor: every valid cycle is compared against the oldest expected pixel,
    // which is popped only when the transfer is accepted.
    initial begin
        forever begin
            @(negedge clk);
            if (pixel_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_pixel: got data %0h row %0d col %0d, expected no pixel",
                             pixel_data, pixel_row, pixel_col);
                end else begin
                    mon_e = sb[0];
                    chk("pixel_data", 32'(pixel_data), 32'(mon_e.d));
                    chk("pixel_row", 32'(pixel_row), 32'(mon_e.r));
                    chk("pixel_col", 32'(pixel_col), 32'(mon_e.c));
                    chk("frame_last", 32'(frame_last), 32'(mon_e.last));
                    if (pixel_ready) void'(sb.pop_front());
                end
            end else begin
                chk("frame_last_no_valid", 32'(frame_last), 0);
            end
        end
    end

    int rr_tbl[10]    = '{1, 1, 0, 0, 2, 2, 0, 0, 0, 0};
    int valid_tbl[10] = '{0, 0, 1, 1, 0, 0, 1, 1, 0, 0};

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        pixel_ready = 1'b1;
        mem[0][0] = 8'h11; mem[0][1] = 8'h22;
        mem[1][0] = 8'h33; mem[1][1] = 8'h44;

        step();
        start = 1'b1;
        step();
        chk_idle("in_reset");
        reset = 1'b0;
        start = 1'b0;
        step();
        chk_idle("after_reset");

        // Full frame with READY high: row select, valid and busy timeline;
        // START during the final transfer cycle must be dropped.
        start = 1'b1;
        push_frame();
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 1) start = 1'b0;
            chk($sformatf("timing_read_row_c%0d", k), 32'(read_row), 32'(rr_tbl[k-1]));
            chk($sformatf("timing_valid_c%0d", k), 32'(pixel_valid), 32'(valid_tbl[k-1]));
            chk($sformatf("timing_busy_c%0d", k), 32'(busy), (k <= 8) ? 32'd1 : 32'd0);
            if (k == 8) start = 1'b1;
            if (k == 9) start = 1'b0;
        end
        chk("frame1_drained", 32'(sb.size()), 0);

        // Backpressure on the first pixel, plus START pulses mid-frame.
        start = 1'b1;
        push_frame();
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 1) start = 1'b0;
            if (k >= 3 && k <= 5) begin
                pixel_ready = 1'b0;
                chk($sformatf("stall_data_c%0d", k), 32'(pixel_data), 32'h11);
                chk($sformatf("stall_valid_c%0d", k), 32'(pixel_valid), 1);
            end
            if (k == 4 || k == 5) start = 1'b1;
            if (k == 6) begin
                pixel_ready = 1'b1;
                start       = 1'b0;
            end
        end
        wait_empty("stall_frame", 1'b0);
        chk("stall_idle", 32'(busy), 0);

        // Reset during row 1 streaming aborts the frame.
        start = 1'b1;
        push_frame();
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 1) start = 1'b0;
            if (k == 7) begin
                pixel_ready = 1'b0;
                reset       = 1'b1;
            end
            if (k == 8) begin
                chk_idle("mid_reset");
                sb.delete();
                start = 1'b1;
            end
            if (k == 9) begin
                reset = 1'b0;
                start = 1'b0;
                chk_idle("post_abort");
                rand_mem();
                pixel_ready = 1'b1;
                start = 1'b1;
                push_frame();
            end
            if (k == 10) start = 1'b0;
        end
        wait_empty("after_abort", 1'b0);

        // START held: back-to-back frames with exactly one idle cycle between.
        start = 1'b1;
        push_frame();
        for (int n = 0; n < 3; n++) begin
            wait_empty("b2b", 1'b0);
            chk($sformatf("b2b_gap_busy_%0d", n), 32'(busy), 0);
            chk($sformatf("b2b_gap_read_row_%0d", n), 32'(read_row), 0);
            if (n < 2) push_frame();
            else start = 1'b0;
            step();
            chk($sformatf("b2b_next_read_row_%0d", n), 32'(read_row), (n < 2) ? 32'd1 : 32'd0);
        end

        // Random frames, random backpressure and ignored mid-frame STARTs.
        for (int f = 0; f < 25; f++) begin
            rand_mem();
            start = 1'b1;
            push_frame();
            step();
            start = 1'b0;
            pixel_ready = ($urandom % 4) != 0;
            wait_empty("rand_frame", 1'b1);
            start = 1'b0;
            pixel_ready = 1'b1;
            chk("rand_idle_busy", 32'(busy), 0);
            step();
        end

        step();
        chk("final_queue_empty", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
